niios_qsys_sysid_checker: RTL and testbench

NIIOS_QSYS_SYSID_CHECKER -- requirements
Module: niios_qsys_sysid_checker

---
 rtl/niios_qsys_sysid_pkg.sv | 32 +++
 rtl/niios_qsys_sysid_timeout_cnt.sv | 41 ++++
 rtl/niios_qsys_sysid_checker.sv | 238 +++++++++++++++++++++++
 tb/tb_niios_qsys_sysid_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/niios_qsys_sysid_pkg.sv
// rtl/niios_qsys_sysid_pkg.sv - shared types and constants for the sysid checker
//
// Purpose: FSM state encoding, sysid word addresses, default expected values
// and a width helper used to size the timeout and retry counters.
package niios_qsys_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_ID  = 3'd1,
    S_WAIT_ID = 3'd2,
    S_REQ_TS  = 3'd3,
    S_WAIT_TS = 3'd4,
    S_FINISH  = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1579320030;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEFAULT_MAX_RETRIES    = 3;

  // Bits needed to hold max_value, never fewer than min_width.
  function automatic int unsigned width_for(input int unsigned max_value,
                                            input int unsigned min_width);
    int unsigned w;
    w = $clog2(max_value + 1);
    return (w < min_width) ? min_width : w;
  endfunction

endpackage

// File: rtl/niios_qsys_sysid_timeout_cnt.sv
// rtl/niios_qsys_sysid_timeout_cnt.sv - loadable up-counter with clear and terminal count
//
// Purpose: measures cycles spent on one sysid read attempt.
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_clear            force count to zero (highest priority)
//   i_load/value       load an arbitrary count
//   i_enable           increment by one
//   o_terminal         count equals TERMINAL
module niios_qsys_sysid_timeout_cnt #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  TERMINAL = '1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_terminal
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_terminal = (r_count == TERMINAL);

endmodule

// File: rtl/niios_qsys_sysid_checker.sv
// rtl/niios_qsys_sysid_checker.sv - reads sysid ID/timestamp over Avalon-MM and checks them
//
// Purpose: on i_start, reads sysid word 0 (ID) then word 1 (timestamp), compares
// each against the expected value, retries timed-out reads and reports the result.
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_start                   one-cycle pulse, ignored while busy
//   o_avm_address, o_avm_read Avalon-MM read command (0 = ID, 1 = timestamp)
//   i_avm_waitrequest         slave stall
//   i_avm_readdata/valid      read response
//   o_busy, o_done            check in progress / one-cycle completion pulse
//   o_pass                    last check result, held until next start
//   o_id_mismatch, o_ts_mismatch, o_timeout   sticky failure flags
//   o_id_read, o_ts_read      last captured words
module niios_qsys_sysid_checker
  import niios_qsys_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEFAULT_MAX_RETRIES
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_avm_address,
  output logic        o_avm_read,
  input  logic        i_avm_waitrequest,
  input  logic [31:0] i_avm_readdata,
  input  logic        i_avm_readdatavalid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_id_mismatch,
  output logic        o_ts_mismatch,
  output logic        o_timeout,
  output logic [31:0] o_id_read,
  output logic [31:0] o_ts_read
);

  localparam int unsigned        CNT_W        = width_for(TIMEOUT_CYCLES, 8);
  localparam int unsigned        RTY_W        = width_for(MAX_RETRIES, 1);
  localparam logic [CNT_W-1:0]   CNT_TERMINAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0]   RTY_MAX      = RTY_W'(MAX_RETRIES);
  localparam logic [RTY_W-1:0]   RTY_ONE      = RTY_W'(1);

  sysid_state_e     r_state;
  logic             r_pass;
  logic             r_id_mm;
  logic             r_ts_mm;
  logic             r_timeout;
  logic [31:0]      r_id_read;
  logic [31:0]      r_ts_read;
  logic [RTY_W-1:0] r_retries;

  sysid_state_e     w_state_nxt;
  sysid_state_e     w_retry_state;
  logic             w_pass_nxt;
  logic             w_id_mm_nxt;
  logic             w_ts_mm_nxt;
  logic             w_timeout_nxt;
  logic [31:0]      w_id_read_nxt;
  logic [31:0]      w_ts_read_nxt;
  logic [RTY_W-1:0] w_retries_nxt;
  logic             w_tmo_event;
  logic             w_cnt_clear;
  logic             w_cnt_en;
  logic             w_cnt_terminal;
  logic             w_avm_read;
  logic             w_avm_address;
  logic             w_busy;
  logic             w_done;

  niios_qsys_sysid_timeout_cnt #(
    .WIDTH    (CNT_W),
    .TERMINAL (CNT_TERMINAL)
  ) u_timeout_cnt (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_cnt_clear),
    .i_load       (1'b0),
    .i_load_value ({CNT_W{1'b0}}),
    .i_enable     (w_cnt_en),
    .o_terminal   (w_cnt_terminal)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pass    <= 1'b0;
      r_id_mm   <= 1'b0;
      r_ts_mm   <= 1'b0;
      r_timeout <= 1'b0;
      r_id_read <= '0;
      r_ts_read <= '0;
      r_retries <= '0;
    end else begin
      r_pass    <= w_pass_nxt;
      r_id_mm   <= w_id_mm_nxt;
      r_ts_mm   <= w_ts_mm_nxt;
      r_timeout <= w_timeout_nxt;
      r_id_read <= w_id_read_nxt;
      r_ts_read <= w_ts_read_nxt;
      r_retries <= w_retries_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_retry_state = S_IDLE;
    w_pass_nxt    = r_pass;
    w_id_mm_nxt   = r_id_mm;
    w_ts_mm_nxt   = r_ts_mm;
    w_timeout_nxt = r_timeout;
    w_id_read_nxt = r_id_read;
    w_ts_read_nxt = r_ts_read;
    w_retries_nxt = r_retries;
    w_tmo_event   = 1'b0;
    w_cnt_clear   = 1'b0;
    w_cnt_en      = 1'b0;
    w_avm_read    = 1'b0;
    w_avm_address = SYSID_ADDR_ID;
    w_busy        = 1'b1;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_state_nxt   = S_REQ_ID;
          w_pass_nxt    = 1'b0;
          w_id_mm_nxt   = 1'b0;
          w_ts_mm_nxt   = 1'b0;
          w_timeout_nxt = 1'b0;
          w_retries_nxt = '0;
          w_cnt_clear   = 1'b1;
        end
      end

      S_REQ_ID: begin
        w_avm_read    = 1'b1;
        w_avm_address = SYSID_ADDR_ID;
        w_cnt_en      = 1'b1;
        if (w_cnt_terminal) begin
          w_tmo_event   = 1'b1;
          w_retry_state = S_REQ_ID;
        end else if (!i_avm_waitrequest) begin
          w_state_nxt = S_WAIT_ID;
        end
      end

      S_WAIT_ID: begin
        w_cnt_en = 1'b1;
        // A response on the terminal cycle still counts as in time.
        if (i_avm_readdatavalid) begin
          w_id_read_nxt = i_avm_readdata;
          w_id_mm_nxt   = (i_avm_readdata != EXPECTED_ID);
          w_state_nxt   = S_REQ_TS;
          w_retries_nxt = '0;
          w_cnt_clear   = 1'b1;
        end else if (w_cnt_terminal) begin
          w_tmo_event   = 1'b1;
          w_retry_state = S_REQ_ID;
        end
      end

      S_REQ_TS: begin
        w_avm_read    = 1'b1;
        w_avm_address = SYSID_ADDR_TS;
        w_cnt_en      = 1'b1;
        if (w_cnt_terminal) begin
          w_tmo_event   = 1'b1;
          w_retry_state = S_REQ_TS;
        end else if (!i_avm_waitrequest) begin
          w_state_nxt = S_WAIT_TS;
        end
      end

      S_WAIT_TS: begin
        w_avm_address = SYSID_ADDR_TS;
        w_cnt_en      = 1'b1;
        if (i_avm_readdatavalid) begin
          w_ts_read_nxt = i_avm_readdata;
          w_ts_mm_nxt   = (i_avm_readdata != EXPECTED_TS);
          w_state_nxt   = S_FINISH;
        end else if (w_cnt_terminal) begin
          w_tmo_event   = 1'b1;
          w_retry_state = S_REQ_TS;
        end
      end

      S_FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Timed-out attempt: re-issue the same word, or give up on the whole check.
    if (w_tmo_event) begin
      if (r_retries < RTY_MAX) begin
        w_retries_nxt = r_retries + RTY_ONE;
        w_state_nxt   = w_retry_state;
        w_cnt_clear   = 1'b1;
      end else begin
        w_timeout_nxt = 1'b1;
        w_state_nxt   = S_FINISH;
      end
    end

    // Resolve pass on entry to FINISH so it is valid alongside the done pulse.
    if ((w_state_nxt == S_FINISH) && (r_state != S_FINISH)) begin
      w_pass_nxt = !(w_id_mm_nxt || w_ts_mm_nxt || w_timeout_nxt);
    end
  end

  assign o_avm_read    = w_avm_read;
  assign o_avm_address = w_avm_address;
  assign o_busy        = w_busy;
  assign o_done        = w_done;
  assign o_pass        = r_pass;
  assign o_id_mismatch = r_id_mm;
  assign o_ts_mismatch = r_ts_mm;
  assign o_timeout     = r_timeout;
  assign o_id_read     = r_id_read;
  assign o_ts_read     = r_ts_read;

endmodule

// File: tb/tb_niios_qsys_sysid_checker.sv
// tb/tb_niios_qsys_sysid_checker.sv - self-checking bench for niios_qsys_sysid_checker
module tb_niios_qsys_sysid_checker;

  localparam int unsigned TO     = 10;
  localparam int unsigned RTY    = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1579320030;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        o_avm_address;
  logic        o_avm_read;
  logic        i_avm_waitrequest;
  logic [31:0] i_avm_readdata;
  logic        i_avm_readdatavalid;
  logic        o_busy, o_done, o_pass;
  logic        o_id_mismatch, o_ts_mismatch, o_timeout;
  logic [31:0] o_id_read, o_ts_read;

  niios_qsys_sysid_checker #(
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRIES    (RTY)
  ) dut (
    .i_clock             (clk),
    .i_reset             (i_reset),
    .i_start             (i_start),
    .o_avm_address       (o_avm_address),
    .o_avm_read          (o_avm_read),
    .i_avm_waitrequest   (i_avm_waitrequest),
    .i_avm_readdata      (i_avm_readdata),
    .i_avm_readdatavalid (i_avm_readdatavalid),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_pass              (o_pass),
    .o_id_mismatch       (o_id_mismatch),
    .o_ts_mismatch       (o_ts_mismatch),
    .o_timeout           (o_timeout),
    .o_id_read           (o_id_read),
    .o_ts_read           (o_ts_read)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_test = "init";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", cur_test, tag, got, exp);
  endtask

  // Slave configuration and bookkeeping
  bit          slave_en = 1'b1;
  logic [31:0] cfg_mem [2];
  bit          cfg_drop [2];
  int          cfg_wait = 0;
  int          cfg_lat  = 1;
  int          acc_cnt [2];
  int          stall_cnt = 0;
  int          pend_cnt  = 0;
  int          pend_addr = 0;
  bit          prev_stall = 1'b0;
  logic        prev_addr  = 1'b0;
  int          done_cnt   = 0;

  // Behavioural Avalon slave: fixed stall per request, fixed response latency.
  initial begin
    i_avm_waitrequest   = 1'b0;
    i_avm_readdatavalid = 1'b0;
    i_avm_readdata      = '0;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (slave_en) begin
        if (prev_stall) begin
          check_eq("hold_read", o_avm_read, 1'b1);
          check_eq("hold_addr", o_avm_address, prev_addr);
        end
        i_avm_readdatavalid = 1'b0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0 && !cfg_drop[pend_addr]) begin
            i_avm_readdatavalid = 1'b1;
            i_avm_readdata      = cfg_mem[pend_addr];
          end
        end
        prev_stall = 1'b0;
        if (o_avm_read) begin
          if (stall_cnt < cfg_wait) begin
            i_avm_waitrequest = 1'b1;
            stall_cnt++;
            prev_stall = 1'b1;
            prev_addr  = o_avm_address;
          end else begin
            i_avm_waitrequest = 1'b0;
            stall_cnt = 0;
            pend_cnt  = cfg_lat;
            pend_addr = int'(o_avm_address);
            acc_cnt[pend_addr]++;
          end
        end else begin
          i_avm_waitrequest = 1'b0;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Reference model state: last captured words survive across checks.
  logic [31:0] m_id_read = '0;
  logic [31:0] m_ts_read = '0;

  task automatic run_check(input string name, input logic [31:0] d0, input logic [31:0] d1,
                           input int w, input int l, input bit drop_id, input bit drop_ts,
                           input bit extra_start);
    bit id_ok, ts_ok, got_done;
    int e_id_acc, e_ts_acc;
    bit e_id_mm, e_ts_mm, e_to, e_pass;
    cur_test    = name;
    cfg_mem[0]  = d0;
    cfg_mem[1]  = d1;
    cfg_drop[0] = drop_id;
    cfg_drop[1] = drop_ts;
    cfg_wait    = w;
    cfg_lat     = l;
    acc_cnt[0]  = 0;
    acc_cnt[1]  = 0;

    // A word is answered in time when stall plus latency fits in the timeout window.
    id_ok = !drop_id && (w + l <= int'(TO));
    ts_ok = !drop_ts && (w + l <= int'(TO));
    e_id_mm = 1'b0;
    e_ts_mm = 1'b0;
    e_id_acc = id_ok ? 1 : int'(RTY) + 1;
    if (id_ok) begin
      m_id_read = d0;
      e_id_mm   = (d0 != EXP_ID);
      e_ts_acc  = ts_ok ? 1 : int'(RTY) + 1;
      if (ts_ok) begin
        m_ts_read = d1;
        e_ts_mm   = (d1 != EXP_TS);
      end
      e_to = !ts_ok;
    end else begin
      e_ts_acc = 0;
      e_to     = 1'b1;
    end
    e_pass = !(e_id_mm || e_ts_mm || e_to);

    @(negedge clk);
    i_start = 1'b1;
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge clk);
      i_start = (extra_start && c == 2);
      if (o_done) got_done = 1'b1;
    end
    i_start = 1'b0;
    check_eq("done_seen", got_done, 1'b1);
    if (got_done) begin
      check_eq("pass",        o_pass,        e_pass);
      check_eq("id_mismatch", o_id_mismatch, e_id_mm);
      check_eq("ts_mismatch", o_ts_mismatch, e_ts_mm);
      check_eq("timeout",     o_timeout,     e_to);
      check_eq("id_read",     o_id_read,     m_id_read);
      check_eq("ts_read",     o_ts_read,     m_ts_read);
      check_eq("id_reqs",     acc_cnt[0],    e_id_acc);
      check_eq("ts_reqs",     acc_cnt[1],    e_ts_acc);
      @(negedge clk);
      check_eq("done_pulse",  o_done,        1'b0);
      check_eq("idle_busy",   o_busy,        1'b0);
      check_eq("pass_held",   o_pass,        e_pass);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    cur_test = name;
    check_eq("busy",        o_busy,        1'b0);
    check_eq("done",        o_done,        1'b0);
    check_eq("pass",        o_pass,        1'b0);
    check_eq("avm_read",    o_avm_read,    1'b0);
    check_eq("avm_address", o_avm_address, 1'b0);
    check_eq("id_mismatch", o_id_mismatch, 1'b0);
    check_eq("ts_mismatch", o_ts_mismatch, 1'b0);
    check_eq("timeout",     o_timeout,     1'b0);
    check_eq("id_read",     o_id_read,     32'd0);
    check_eq("ts_read",     o_ts_read,     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_snap;
    bit waited;
    cfg_mem[0]  = EXP_ID;
    cfg_mem[1]  = EXP_TS;
    cfg_drop[0] = 1'b0;
    cfg_drop[1] = 1'b0;
    i_start = 1'b0;
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    i_reset = 1'b0;

    run_check("basic",       EXP_ID,        EXP_TS, 0, 1,  0, 0, 0);
    run_check("id_mismatch", 32'h12345678,  EXP_TS, 0, 1,  0, 0, 0);
    run_check("restart",     EXP_ID,        EXP_TS, 0, 1,  0, 0, 0);
    run_check("wait5",       EXP_ID,        EXP_TS, 5, 1,  0, 0, 0);
    run_check("ts_drop",     EXP_ID,        EXP_TS, 0, 1,  0, 1, 0);
    run_check("lat_edge",    EXP_ID,        EXP_TS, 5, 5,  0, 0, 0);
    run_check("lat_over",    32'hABCD0001,  EXP_TS, 0, 11, 0, 0, 0);
    run_check("busy_start",  EXP_ID,        32'h1,  2, 3,  0, 0, 1);

    // Reset while waiting for the ID response, then a stray late valid.
    cur_test = "mid_reset";
    cfg_mem[0] = 32'h0BADF00D;
    cfg_mem[1] = EXP_TS;
    cfg_drop[0] = 1'b0;
    cfg_drop[1] = 1'b0;
    cfg_wait = 0;
    cfg_lat  = 5;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    waited = 1'b0;
    for (int c = 0; c < 20 && !waited; c++) begin
      if (acc_cnt[0] == 1) waited = 1'b1;
      else @(negedge clk);
    end
    check_eq("id_issued", waited, 1'b1);
    @(negedge clk);
    slave_en = 1'b0;
    pend_cnt = 0;
    i_avm_readdatavalid = 1'b0;
    i_avm_waitrequest   = 1'b0;
    done_snap = done_cnt;
    #1 i_reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    i_avm_readdatavalid = 1'b1;
    i_avm_readdata      = 32'hDEADBEEF;
    @(negedge clk);
    i_avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    cur_test = "after_reset";
    check_eq("busy",     o_busy,    1'b0);
    check_eq("avm_read", o_avm_read, 1'b0);
    check_eq("id_read",  o_id_read, 32'd0);
    check_eq("no_done",  done_cnt,  done_snap);
    m_id_read = '0;
    m_ts_read = '0;
    slave_en  = 1'b1;
    run_check("post_reset", EXP_ID, EXP_TS, 1, 2, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] d0, d1;
      d0 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      d1 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      run_check($sformatf("rand%0d", i), d0, d1,
                int'($urandom_range(0, 5)), int'($urandom_range(1, 7)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
